iface_xform_arbiter: RTL and testbench



---
 rtl/iface_xform_pkg.sv | 13 +
 rtl/iface_xform_if.sv | 10 +
 rtl/rr_pick.sv | 33 +++
 rtl/iface_xform_arbiter.sv | 92 +++++++++
 tb/tb_iface_xform_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/iface_xform_pkg.sv
// Shared types and constants for the transform-resource arbiter slice.
package iface_xform_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam int MAX_LAT = 7;

   // Keeps a legal one-bit index even in a degenerate single-requester build.
   function automatic int idWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/iface_xform_if.sv
// Bundle between the arbiter and the on-demand transform module.
interface iface_xform_if #(parameter int W = 8);

   logic [W-1:0] x;
   logic [W-1:0] y;

   modport requester (output x, input y);
   modport resource  (input x, output y);

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching cyclically after ptr_i.
module rr_pick
   import iface_xform_pkg::*;
#(
   parameter int N = 4,
   localparam int IW = idWidth(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   always_comb begin
      int  j;
      logic found;
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      j       = 0;
      for (int k = 1; k <= N; k++) begin
         j = (int'(ptr_i) + k) % N;
         if (!found && req_i[j]) begin
            found      = 1'b1;
            idx_o      = IW'(j);
            grant_o[j] = 1'b1;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/iface_xform_arbiter.sv
// Round-robin sequencer sharing one fixed-latency transform resource among N requesters.
module iface_xform_arbiter
   import iface_xform_pkg::*;
#(
   parameter int N   = 4,
   parameter int W   = 8,
   parameter int LAT = 0,
   localparam int IW = idWidth(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req_valid,
   output logic [N-1:0]  req_ready,
   input  logic [N*W-1:0] req_data,
   output logic [N-1:0]  rsp_valid,
   input  logic [N-1:0]  rsp_ready,
   output logic [W-1:0]  rsp_data,
   output logic [W-1:0]  xf_x,
   input  logic [W-1:0]  xf_y,
   output logic          busy,
   output logic [IW-1:0] grant_id
);

   localparam int CW = $clog2(MAX_LAT + 1);

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [IW-1:0] ptr_q;
   logic [IW-1:0] grant_q;
   logic [W-1:0]  xfX_q;
   logic [W-1:0]  rspData_q;

   logic [N-1:0]  pickGrant;
   logic [IW-1:0] pickIdx;
   logic          pickAny;
   logic [W-1:0]  pickData;

   rr_pick #(.N(N)) u_pick (
      .req_i   (req_valid),
      .ptr_i   (ptr_q),
      .grant_o (pickGrant),
      .idx_o   (pickIdx),
      .any_o   (pickAny)
   );

   assign pickData  = req_data[pickIdx*W +: W];
   assign req_ready = (state_q == IDLE) ? pickGrant : '0;
   assign rsp_valid = (state_q == RESP) ? ({{(N-1){1'b0}}, 1'b1} << grant_q) : '0;
   assign busy      = (state_q != IDLE);
   assign rsp_data  = rspData_q;
   assign xf_x      = xfX_q;
   assign grant_id  = grant_q;

   // Pointer moves only when a response is accepted, which is what bounds waiting to N transactions.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ptr_q     <= IW'(N - 1);
         grant_q   <= '0;
         xfX_q     <= '0;
         rspData_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (pickAny) begin
                  xfX_q   <= pickData;
                  grant_q <= pickIdx;
                  cnt_q   <= CW'(LAT);
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  rspData_q <= xf_y;
                  state_q   <= RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready[grant_q]) begin
                  ptr_q   <= grant_q;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iface_xform_arbiter.sv
// Drives a combinational (LAT=0) and a 3-stage (LAT=3) instance with shared stimulus against a transaction-level model.
module tb_iface_xform_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   reqValid = '0;
   logic [N-1:0]   rspReady = '0;
   logic [N*W-1:0] reqData = '0;

   logic [N-1:0] rr0, rv0, rr3, rv3;
   logic [W-1:0] rd0, xx0, rd3, xx3;
   logic         busy0, busy3;
   logic [1:0]   gid0, gid3;
   logic [W-1:0] p1, p2, p3;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   bit         mBusy  [2];
   int         mAge   [2];
   int         mGrant [2];
   int         mLast  [2];
   logic [W-1:0] mOp  [2];
   logic [W-1:0] mRes [2];

   iface_xform_if #(.W(W)) bus0 ();
   iface_xform_if #(.W(W)) bus3 ();

   always #5 clk = ~clk;

   assign bus0.x = xx0;
   assign bus0.y = ~bus0.x;

   // Resource with three register stages in front of the inverter output.
   always @(posedge clk) begin
      if (rst) begin
         p1 <= '0; p2 <= '0; p3 <= '0;
      end else begin
         p1 <= ~bus3.x; p2 <= p1; p3 <= p2;
      end
   end
   assign bus3.x = xx3;
   assign bus3.y = p3;

   iface_xform_arbiter #(.N(N), .W(W), .LAT(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(rr0), .req_data(reqData),
      .rsp_valid(rv0), .rsp_ready(rspReady), .rsp_data(rd0), .xf_x(xx0), .xf_y(bus0.y),
      .busy(busy0), .grant_id(gid0)
   );

   iface_xform_arbiter #(.N(N), .W(W), .LAT(3)) dut3 (
      .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(rr3), .req_data(reqData),
      .rsp_valid(rv3), .rsp_ready(rspReady), .rsp_data(rd3), .xf_x(xx3), .xf_y(bus3.y),
      .busy(busy3), .grant_id(gid3)
   );

   task automatic cmp(input string nm, input int inst, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s inst=%0d cycle=%0d got=%h expected=%h", nm, inst, cyc, got, exp);
      end
   endtask

   task automatic modelReset(input int i);
      mBusy[i] = 1'b0; mAge[i] = 0; mGrant[i] = 0; mLast[i] = N - 1;
      mOp[i] = '0; mRes[i] = '0;
   endtask

   function automatic int pickFirst(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++)
         if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   // Compares both instances against the model for this cycle, then advances the model.
   task automatic checkOutput();
      logic [N-1:0] aRR [2];
      logic [N-1:0] aRV [2];
      logic [W-1:0] aRD [2];
      logic [W-1:0] aXX [2];
      logic         aB  [2];
      logic [1:0]   aG  [2];
      aRR[0] = rr0; aRV[0] = rv0; aRD[0] = rd0; aXX[0] = xx0; aB[0] = busy0; aG[0] = gid0;
      aRR[1] = rr3; aRV[1] = rv3; aRD[1] = rd3; aXX[1] = xx3; aB[1] = busy3; aG[1] = gid3;
      for (int i = 0; i < 2; i++) begin
         int lat, cand;
         bit idle, inWait, inResp;
         logic [N-1:0] eRR, eRV;
         lat    = (i == 0) ? 0 : 3;
         idle   = !mBusy[i];
         inWait = mBusy[i] && (mAge[i] <= lat + 1);
         inResp = mBusy[i] && (mAge[i] >= lat + 2);
         cand   = pickFirst(reqValid, mLast[i]);
         eRR = '0; eRV = '0;
         if (idle && cand >= 0) eRR[cand] = 1'b1;
         if (inResp) eRV[mGrant[i]] = 1'b1;
         cmp("req_ready", i, 32'(aRR[i]), 32'(eRR));
         cmp("rsp_valid", i, 32'(aRV[i]), 32'(eRV));
         cmp("rsp_data",  i, 32'(aRD[i]), 32'(mRes[i]));
         cmp("xf_x",      i, 32'(aXX[i]), 32'(mOp[i]));
         cmp("busy",      i, 32'(aB[i]),  32'(mBusy[i]));
         cmp("grant_id",  i, 32'(aG[i]),  32'(mGrant[i]));
         cmp("onehot",    i, 32'(($countones(aRR[i]) <= 1) && ($countones(aRV[i]) <= 1)), 32'd1);
         if (rst) begin
            modelReset(i);
         end else if (idle && cand >= 0) begin
            mBusy[i] = 1'b1; mAge[i] = 1; mGrant[i] = cand;
            mOp[i] = reqData[cand*W +: W];
         end else if (inWait) begin
            mAge[i]++;
            if (mAge[i] == lat + 2) mRes[i] = ~mOp[i];
         end else if (inResp && rspReady[mGrant[i]]) begin
            mBusy[i] = 1'b0; mLast[i] = mGrant[i];
         end
      end
      cyc++;
   endtask

   task automatic applyStimulus(input logic [N-1:0] rv, input logic [N*W-1:0] rd,
                                input logic [N-1:0] rr, input logic r);
      @(posedge clk); #1;
      reqValid = rv; reqData = rd; rspReady = rr; rst = r;
      @(negedge clk);
      checkOutput();
   endtask

   task automatic resetDut();
      applyStimulus('0, '0, '0, 1'b1);
      applyStimulus('0, '0, '0, 1'b1);
   endtask

   task automatic drain(input int n);
      for (int k = 0; k < n; k++) applyStimulus('0, '0, 4'hF, 1'b0);
   endtask

   logic [W-1:0] t2Res [4] = '{8'hFF, 8'hEE, 8'hDD, 8'hCC};

   initial begin
      modelReset(0);
      modelReset(1);
      resetDut();

      // Single request from requester 2 on the combinational instance.
      applyStimulus(4'b0100, 32'h003C_0000, 4'h0, 1'b0);
      cmp("t1_ready", 0, 32'(rr0), 32'b0100);
      applyStimulus('0, '0, 4'h0, 1'b0);
      applyStimulus('0, '0, 4'h0, 1'b0);
      cmp("t1_rsp_valid", 0, 32'(rv0), 32'b0100);
      cmp("t1_rsp_data",  0, 32'(rd0), 32'hC3);
      drain(7);

      // All requesters contending: strict rotation, three cycles per transaction.
      resetDut();
      for (int c = 0; c < 15; c++) begin
         applyStimulus(4'hF, 32'h3322_1100, 4'hF, 1'b0);
         if (c % 3 == 0) cmp("t2_grant", 0, 32'(rr0), 32'(1) << ((c / 3) % 4));
         if (c % 3 == 2) cmp("t2_result", 0, 32'({rv0, rd0}),
                             {20'd0, 4'(1 << ((c / 3) % 4)), t2Res[(c / 3) % 4]});
      end
      drain(8);

      // Backpressure on requester 1, with a stray ready on requester 3.
      resetDut();
      applyStimulus(4'b0010, 32'h0000_5F00, 4'h0, 1'b0);
      cmp("t3_ready", 0, 32'(rr0), 32'b0010);
      applyStimulus(4'hF, 32'h4433_2211, 4'h0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         applyStimulus(4'hF, 32'h4433_2211, 4'b1000, 1'b0);
         cmp("t3_hold", 0, 32'({rv0, rd0, rr0, 2'(gid0)}), {14'd0, 4'b0010, 8'hA0, 4'b0000, 2'd1});
      end
      applyStimulus(4'hF, 32'h4433_2211, 4'b0010, 1'b0);
      cmp("t3_last_valid", 0, 32'(rv0), 32'b0010);
      applyStimulus(4'hF, 32'h4433_2211, 4'h0, 1'b0);
      cmp("t3_next_grant", 0, 32'(rr0), 32'b0100);
      drain(10);

      // Latency 3 instance: operand held four cycles, result one cycle later.
      resetDut();
      applyStimulus(4'b0001, 32'h0000_00A5, 4'h0, 1'b0);
      for (int c = 1; c <= 4; c++) begin
         applyStimulus('0, '0, 4'h0, 1'b0);
         cmp("t4_xf_x", 1, 32'({rv3, xx3}), {20'd0, 4'b0000, 8'hA5});
      end
      applyStimulus('0, '0, 4'h1, 1'b0);
      cmp("t4_rsp", 1, 32'({rv3, rd3}), {20'd0, 4'b0001, 8'h5A});
      drain(4);

      // Reset while a transaction is in WAIT.
      resetDut();
      applyStimulus(4'b1000, 32'h7700_0000, 4'h0, 1'b0);
      cmp("t5_ready", 0, 32'(rr0), 32'b1000);
      applyStimulus('0, '0, 4'h0, 1'b1);
      cmp("t5_wait", 0, 32'({busy0, rv0}), {27'd0, 1'b1, 4'b0000});
      applyStimulus(4'b1001, 32'h7700_0011, 4'hF, 1'b0);
      cmp("t5_after_reset", 0, 32'({rv0, rr0}), {24'd0, 4'b0000, 4'b0001});
      drain(8);

      // Random traffic, including occasional resets.
      for (int c = 0; c < 400; c++)
         applyStimulus(4'($urandom_range(0, 15)), 32'($urandom), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 59) == 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
